// File: rtl/inv_tree_pipe.sv
// Clocked inverter fanout tree: source select / toggle generator, root stage,
// LEVELS of registered binary splits, per-leaf transition counters, sticky mismatch flag.

module inv_leaf_lane #(
  parameter int   CNT_W = 16,
  parameter logic RST_V = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_par,
  input  logic             i_clr,
  output logic             o_q,
  output logic [CNT_W-1:0] o_cnt
);
  logic             w_d, w_tog;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;

  assign w_d   = ~i_par;
  // Count on the same edge the leaf changes, so clear and transition collide cleanly.
  assign w_tog = w_d ^ r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= RST_V;
      r_cnt <= '0;
    end else begin
      r_q <= w_d;
      if (i_clr)
        r_cnt <= '0;
      else if (w_tog && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_q   = r_q;
  assign o_cnt = r_cnt;
endmodule

module inv_tree_pipe #(
  parameter int LEVELS    = 2,
  parameter int CHAIN_LEN = 5,
  parameter int CNT_W     = 16,
  parameter int PW        = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            din,
  input  logic                            stim_en,
  input  logic [PW-1:0]                   stim_period,
  input  logic                            cnt_clr,
  output logic                            src_out,
  output logic [(1<<LEVELS)-1:0]          dout,
  output logic [(1<<LEVELS)*CNT_W-1:0]    leaf_cnt,
  output logic                            err
);
  localparam int   NLEAF   = 1 << LEVELS;
  localparam int   NINT    = NLEAF - 1;
  localparam logic CPAR    = 1'(CHAIN_LEN % 2);
  localparam logic INV_PAR = 1'((CHAIN_LEN + LEVELS) % 2);

  logic            r_src, r_err;
  logic [PW-1:0]   r_scnt, w_pm1;
  logic [NINT-1:0] w_node;
  logic            w_mis;

  assign w_pm1 = (stim_period == '0) ? '0 : stim_period - PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src  <= 1'b0;
      r_scnt <= '0;
    end else if (!stim_en) begin
      r_src  <= din;
      r_scnt <= '0;
    end else if (r_scnt == w_pm1) begin
      r_src  <= ~r_src;
      r_scnt <= '0;
    end else begin
      r_scnt <= r_scnt + PW'(1);
    end
  end

  // Internal nodes in heap order: node n has children 2n+1, 2n+2; level = floor(log2(n+1)).
  for (genvar n = 0; n < NINT; n++) begin : g_node
    localparam int   LV = $clog2(n + 2) - 1;
    localparam logic RV = 1'((CHAIN_LEN + LV) % 2);
    logic r_q;
    if (n == 0) begin : g_root
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RV;
        else        r_q <= r_src ^ CPAR;
      end
    end else begin : g_int
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= RV;
        else        r_q <= ~w_node[(n-1)/2];
      end
    end
    assign w_node[n] = r_q;
  end

  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    inv_leaf_lane #(.CNT_W(CNT_W), .RST_V(INV_PAR)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_par (w_node[(NINT+i-1)/2]),
      .i_clr (cnt_clr),
      .o_q   (dout[i]),
      .o_cnt (leaf_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign w_mis = (|dout) & ~(&dout);

  // A mismatch sampled in the clear cycle still sets the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_mis | (r_err & ~cnt_clr);
  end

  assign src_out = r_src;
  assign err     = r_err;
endmodule

// File: tb/tb_inv_tree_pipe.sv
// Directed bench for inv_tree_pipe: per-cycle scoreboard of src/dout/err plus
// directed checks of counters, saturation, clear priority, mismatch and async reset.

module tb_inv_tree_pipe;
  localparam int LEVELS    = 2;
  localparam int CHAIN_LEN = 5;
  localparam int PW        = 8;
  localparam int NLEAF     = 1 << LEVELS;
  localparam bit INV       = 1'((CHAIN_LEN + LEVELS) % 2);

  logic clk = 1'b0, rst_n = 1'b1, din = 1'b0, stim_en = 1'b0, cnt_clr = 1'b0;
  logic [PW-1:0] stim_period = '0;
  logic src_out, src_out4, err, err4;
  logic [NLEAF-1:0] dout, dout4;
  logic [NLEAF*16-1:0] leaf_cnt;
  logic [NLEAF*4-1:0]  leaf_cnt4;

  inv_tree_pipe #(.LEVELS(LEVELS), .CHAIN_LEN(CHAIN_LEN), .CNT_W(16), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .stim_en(stim_en), .stim_period(stim_period),
    .cnt_clr(cnt_clr), .src_out(src_out), .dout(dout), .leaf_cnt(leaf_cnt), .err(err));

  inv_tree_pipe #(.LEVELS(LEVELS), .CHAIN_LEN(CHAIN_LEN), .CNT_W(4), .PW(PW)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .stim_en(stim_en), .stim_period(stim_period),
    .cnt_clr(cnt_clr), .src_out(src_out4), .dout(dout4), .leaf_cnt(leaf_cnt4), .err(err4));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  bit src_m, dexp, err_m, force_now, skip_dout, fv;
  int scnt_m;
  bit q_m[$];
  int cnt_m[NLEAF];
  int cnt4_m[NLEAF];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    src_m = 1'b0; scnt_m = 0; err_m = 1'b0; dexp = INV;
    q_m.delete();
    repeat (LEVELS+1) q_m.push_back(1'b0);
    for (int i = 0; i < NLEAF; i++) begin cnt_m[i] = 0; cnt4_m[i] = 0; end
  endtask

  // One clock: update the model from the inputs sampled at this edge, then compare.
  task automatic step();
    bit nd;
    int pm1;
    @(posedge clk);
    if (!stim_en) begin
      src_m = din; scnt_m = 0;
    end else begin
      pm1 = (stim_period == 0) ? 0 : int'(stim_period) - 1;
      if (scnt_m == pm1) begin src_m = ~src_m; scnt_m = 0; end
      else scnt_m = (scnt_m + 1) % 256;
    end
    q_m.push_back(src_m);
    nd = q_m.pop_front() ^ INV;
    for (int i = 0; i < NLEAF; i++) begin
      if (cnt_clr) begin cnt_m[i] = 0; cnt4_m[i] = 0; end
      else if (nd != dexp) begin
        if (cnt_m[i] < 65535) cnt_m[i]++;
        if (cnt4_m[i] < 15) cnt4_m[i]++;
      end
    end
    dexp  = nd;
    err_m = (err_m && !cnt_clr) || force_now;
    #1;
    chk("src_out", 64'(src_out), 64'(src_m));
    chk("src_out4", 64'(src_out4), 64'(src_m));
    if (!skip_dout) chk("dout", 64'(dout), 64'({NLEAF{dexp}}));
    chk("dout4", 64'(dout4), 64'({NLEAF{dexp}}));
    chk("err", 64'(err), 64'(err_m));
  endtask

  task automatic quiet();
    din = src_m; stim_en = 1'b0;
    repeat (LEVELS+2) step();
  endtask

  task automatic chk_all(input string tag, input int v);
    for (int i = 0; i < NLEAF; i++) chk(tag, 64'(leaf_cnt[i*16 +: 16]), 64'(v));
  endtask

  task automatic chk_all4(input string tag, input int v);
    for (int i = 0; i < NLEAF; i++) chk(tag, 64'(leaf_cnt4[i*4 +: 4]), 64'(v));
  endtask

  task automatic chk_model(input string tag);
    for (int i = 0; i < NLEAF; i++) begin
      chk(tag, 64'(leaf_cnt[i*16 +: 16]), 64'(cnt_m[i]));
      chk(tag, 64'(leaf_cnt4[i*4 +: 4]), 64'(cnt4_m[i]));
    end
  endtask

  initial begin
    int lat;
    model_reset();
    // Reset applied and checked before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'(4'b1111));
    chk("rst_src", 64'(src_out), 64'd0);
    chk("rst_cnt", 64'(leaf_cnt), 64'd0);
    chk("rst_cnt4", 64'(leaf_cnt4), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err4", 64'(err4), 64'd0);
    #1 rst_n = 1'b1;
    repeat (3) step();

    // Pass-through latency.
    din = 1'b1;
    step();
    chk("pt_src", 64'(src_out), 64'd1);
    step(); step();
    chk("pt_hold", 64'(dout), 64'(4'b1111));
    step();
    chk("pt_dout", 64'(dout), 64'(4'b0000));
    chk_all("pt_cnt", 1);
    chk("pt_err", 64'(err), 64'd0);

    // Toggle generator, period 3 then period 0.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    stim_period = 8'd3; stim_en = 1'b1;
    repeat (33) step();
    quiet();
    chk_all("stim3_cnt", 11);
    chk_model("stim3_model");

    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    stim_period = 8'd0; stim_en = 1'b1;
    repeat (33) step();
    quiet();
    chk_all("stim0_cnt", 33);
    chk_model("stim0_model");

    // Saturation of the narrow counters.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    stim_period = 8'd1; stim_en = 1'b1;
    repeat (40) step();
    chk_all4("sat_cnt", 15);
    repeat (5) step();
    chk_all4("sat_hold", 15);
    chk_model("sat_model");
    quiet();

    // Clear coincident with a leaf transition wins.
    din = ~src_m;
    repeat (3) step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk_all("clr_prio", 0);
    din = ~din;
    repeat (LEVELS+3) step();
    chk_all("clr_next", 1);

    // Injected leaf mismatch: sticky err, cleared by cnt_clr.
    quiet();
    fv = ~dexp;
    force dut.g_leaf[NLEAF-1].u_lane.r_q = fv;
    force_now = 1'b1; skip_dout = 1'b1;
    step();
    chk("mis_err_set", 64'(err), 64'd1);
    release dut.g_leaf[NLEAF-1].u_lane.r_q;
    skip_dout = 1'b0;
    step();
    force_now = 1'b0;
    chk("mis_err_sticky", 64'(err), 64'd1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("mis_err_clr", 64'(err), 64'd0);
    chk_model("mis_cnt");

    // Asynchronous reset mid-stimulus, then restart latency.
    stim_period = 8'd3; stim_en = 1'b1;
    repeat (7) step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dout", 64'(dout), 64'({NLEAF{INV}}));
    chk("arst_src", 64'(src_out), 64'd0);
    chk("arst_cnt", 64'(leaf_cnt), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      lat++;
      if (dout !== {NLEAF{INV}}) break;
    end
    chk("arst_lat", 64'(lat), 64'(3 + LEVELS + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
